// File: rtl/fetch_decode_buffer_if.sv
// Fetch/Decode handshake bundle for the IF/ID buffer.
// master: the Fetch/Decode side that drives in_*, stall and flush.
// slave:  the buffer itself.
interface fetch_decode_buffer_if #(
    parameter int INST_W = 16,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              stall;
    logic              flush;
    logic              fetch_hold;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [INST_W-1:0] out_imm;
    logic [PC_W-1:0]   out_pc;
    logic              out_long;

    modport master (
        output in_valid, in_inst, in_pc, stall, flush,
        input  fetch_hold, out_valid, out_inst, out_imm, out_pc, out_long
    );

    modport slave (
        input  in_valid, in_inst, in_pc, stall, flush,
        output fetch_hold, out_valid, out_inst, out_imm, out_pc, out_long
    );
endinterface

// File: rtl/fetch_decode_buffer.sv
// IF/ID pipeline register. Assembles two-word (opcode + immediate)
// instructions and issues each instruction to Decode as one unit.
// Priority per edge: reset > flush > stall > normal.
// Optional feature macro: FETCH_BUF_CNT_EN adds a 16-bit issued-instruction
// counter on port inst_count.
module fetch_decode_buffer #(
    parameter int INST_W        = 16,
    parameter int PC_W          = 32,
    parameter int LONG_FLAG_BIT = 15
) (
    input  logic clk,
    input  logic reset,
    fetch_decode_buffer_if.slave bus
`ifdef FETCH_BUF_CNT_EN
    ,
    output logic [15:0] inst_count
`endif
);
    typedef enum logic {S_FIRST = 1'b0, S_SECOND = 1'b1} state_t;

    state_t            state;
    logic [INST_W-1:0] pend_inst;
    logic [PC_W-1:0]   pend_pc;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [INST_W-1:0] out_imm;
    logic [PC_W-1:0]   out_pc;
    logic              out_long;
    logic              advance;
    logic              issue;

    // An edge does normal work only when nothing of higher priority is active.
    assign advance = !reset && !bus.flush && !bus.stall;
    // A complete instruction reaches out_* this edge (short, or long's second word).
    assign issue   = advance && bus.in_valid &&
                     (state == S_SECOND || !bus.in_inst[LONG_FLAG_BIT]);

    // Fetch must re-present its word while Decode stalls, unless we are flushing.
    assign bus.fetch_hold = bus.stall & ~bus.flush;
    assign bus.out_valid  = out_valid;
    assign bus.out_inst   = out_inst;
    assign bus.out_imm    = out_imm;
    assign bus.out_pc     = out_pc;
    assign bus.out_long   = out_long;

    // Assembly FSM and output register; partial instructions die on reset/flush.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            state     <= S_FIRST;
            pend_inst <= '0;
            pend_pc   <= '0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
            out_long  <= 1'b0;
        end else if (!bus.stall) begin
            // Valid is a one-edge pulse; fields of a non-issuing edge keep last values.
            out_valid <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    S_FIRST: begin
                        if (bus.in_inst[LONG_FLAG_BIT]) begin
                            pend_inst <= bus.in_inst;
                            pend_pc   <= bus.in_pc;
                            state     <= S_SECOND;
                        end else begin
                            out_valid <= 1'b1;
                            out_inst  <= bus.in_inst;
                            out_imm   <= '0;
                            out_pc    <= bus.in_pc;
                            out_long  <= 1'b0;
                        end
                    end
                    S_SECOND: begin
                        // The immediate's flag bit is data, not a new-instruction marker.
                        out_valid <= 1'b1;
                        out_inst  <= pend_inst;
                        out_imm   <= bus.in_inst;
                        out_pc    <= pend_pc;
                        out_long  <= 1'b1;
                        state     <= S_FIRST;
                    end
                    default: state <= S_FIRST;
                endcase
            end
        end
    end

`ifdef FETCH_BUF_CNT_EN
    // Issued-instruction counter: survives flush, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)
            inst_count <= '0;
        else if (issue)
            inst_count <= inst_count + 16'd1;
    end
`else
    logic unused_issue;
    assign unused_issue = issue;
`endif
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: directed table, hand sequences and a
// randomized run against a queue-based reference model.
// Define FETCH_BUF_CNT_EN to also cover the instruction counter.
module tb_fetch_decode_buffer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_decode_buffer_if #(.INST_W(16), .PC_W(32)) bus ();
`ifdef FETCH_BUF_CNT_EN
    logic [15:0] inst_count;
`endif

    fetch_decode_buffer #(.INST_W(16), .PC_W(32), .LONG_FLAG_BIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef FETCH_BUF_CNT_EN
        ,
        .inst_count (inst_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue holds at most one waiting opcode word.
    typedef struct { logic [15:0] inst; logic [31:0] pc; } word_t;
    word_t       pend_q[$];
    logic        m_valid, m_long;
    logic [15:0] m_inst, m_imm;
    logic [31:0] m_pc;
    int          m_count;

    function automatic void model_edge(input logic r, input logic f, input logic s,
                                       input logic v, input logic [15:0] i, input logic [31:0] p);
        if (r || f) begin
            m_valid = 0; m_inst = 0; m_imm = 0; m_pc = 0; m_long = 0;
            pend_q.delete();
            if (r) m_count = 0;
        end else if (!s) begin
            m_valid = 0;
            if (v) begin
                if (pend_q.size() != 0) begin
                    word_t w = pend_q.pop_front();
                    m_valid = 1; m_inst = w.inst; m_imm = i; m_pc = w.pc; m_long = 1;
                    m_count = (m_count + 1) % 65536;
                end else if (i[15]) begin
                    pend_q.push_back('{i, p});
                end else begin
                    m_valid = 1; m_inst = i; m_imm = 0; m_pc = p; m_long = 0;
                    m_count = (m_count + 1) % 65536;
                end
            end
        end
    endfunction

    // Drive one cycle's inputs, check fetch_hold, clock, advance the model.
    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [15:0] i, input logic [31:0] p, input logic do_hold_chk);
        reset = r; bus.flush = f; bus.stall = s; bus.in_valid = v;
        bus.in_inst = i; bus.in_pc = p;
        #1;
        if (do_hold_chk) chk("fetch_hold", 64'(bus.fetch_hold), 64'(s & ~f));
        @(posedge clk);
        model_edge(r, f, s, v, i, p);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
        chk({tag, ".out_inst"},  64'(bus.out_inst),  64'(m_inst));
        chk({tag, ".out_imm"},   64'(bus.out_imm),   64'(m_imm));
        chk({tag, ".out_pc"},    64'(bus.out_pc),    64'(m_pc));
        chk({tag, ".out_long"},  64'(bus.out_long),  64'(m_long));
`ifdef FETCH_BUF_CNT_EN
        chk({tag, ".inst_count"}, 64'(inst_count), 64'(m_count));
`endif
    endtask

    typedef struct {
        logic        r, f, s, v;
        logic [15:0] i;
        logic [31:0] p;
        logic        e_hold, e_v;
        logic [15:0] e_inst, e_imm;
        logic [31:0] e_pc;
        logic        e_long;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic s, logic v, logic [15:0] i, logic [31:0] p,
                                logic ev, logic [15:0] ei, logic [15:0] em, logic [31:0] ep, logic el);
        vec_t t;
        t.r = r; t.f = f; t.s = s; t.v = v; t.i = i; t.p = p;
        t.e_hold = s & ~f; t.e_v = ev; t.e_inst = ei; t.e_imm = em; t.e_pc = ep; t.e_long = el;
        return t;
    endfunction

    vec_t tbl[17];

    initial begin
        reset = 1; bus.flush = 0; bus.stall = 0; bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0;
        m_count = 0;

        //             r  f  s  v  inst      pc   -> v  inst     imm      pc  long
        tbl[0]  = mk(1, 0, 0, 0, 16'h0000, 0,    0, 16'h0000, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 16'h8123, 3,    0, 16'h0000, 16'h0000, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 16'h1234, 5,    1, 16'h1234, 16'h0000, 5, 0);
        tbl[3]  = mk(0, 0, 0, 1, 16'h8001, 6,    0, 16'h1234, 16'h0000, 5, 0);
        tbl[4]  = mk(0, 0, 0, 1, 16'h80FF, 7,    1, 16'h8001, 16'h80FF, 6, 1);
        tbl[5]  = mk(0, 0, 0, 1, 16'h8001, 6,    0, 16'h8001, 16'h80FF, 6, 1);
        tbl[6]  = mk(0, 1, 0, 1, 16'h00FF, 7,    0, 16'h0000, 16'h0000, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 16'h0042, 8,    1, 16'h0042, 16'h0000, 8, 0);
        tbl[8]  = mk(0, 0, 0, 1, 16'h8001, 9,    0, 16'h0042, 16'h0000, 8, 0);
        tbl[9]  = mk(0, 0, 1, 1, 16'h80FF, 10,   0, 16'h0042, 16'h0000, 8, 0);
        tbl[10] = mk(0, 0, 1, 1, 16'h80FF, 10,   0, 16'h0042, 16'h0000, 8, 0);
        tbl[11] = mk(0, 0, 1, 1, 16'h80FF, 10,   0, 16'h0042, 16'h0000, 8, 0);
        tbl[12] = mk(0, 0, 0, 1, 16'h80FF, 10,   1, 16'h8001, 16'h80FF, 9, 1);
        tbl[13] = mk(0, 0, 1, 1, 16'h1111, 11,   1, 16'h8001, 16'h80FF, 9, 1);
        tbl[14] = mk(0, 0, 0, 0, 16'h1111, 11,   0, 16'h8001, 16'h80FF, 9, 1);
        tbl[15] = mk(0, 1, 1, 1, 16'h2222, 12,   0, 16'h0000, 16'h0000, 0, 0);
        tbl[16] = mk(1, 0, 0, 1, 16'h0001, 13,   0, 16'h0000, 16'h0000, 0, 0);

        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            reset = tbl[k].r; bus.flush = tbl[k].f; bus.stall = tbl[k].s; bus.in_valid = tbl[k].v;
            bus.in_inst = tbl[k].i; bus.in_pc = tbl[k].p;
            #1;
            chk($sformatf("t%0d.fetch_hold", k), 64'(bus.fetch_hold), 64'(tbl[k].e_hold));
            @(posedge clk);
            model_edge(tbl[k].r, tbl[k].f, tbl[k].s, tbl[k].v, tbl[k].i, tbl[k].p);
            #1;
            chk($sformatf("t%0d.out_valid", k), 64'(bus.out_valid), 64'(tbl[k].e_v));
            chk($sformatf("t%0d.out_inst", k),  64'(bus.out_inst),  64'(tbl[k].e_inst));
            chk($sformatf("t%0d.out_imm", k),   64'(bus.out_imm),   64'(tbl[k].e_imm));
            chk($sformatf("t%0d.out_pc", k),    64'(bus.out_pc),    64'(tbl[k].e_pc));
            chk($sformatf("t%0d.out_long", k),  64'(bus.out_long),  64'(tbl[k].e_long));
        end

        // Reset in S_SECOND must discard the opcode; next word decodes as an opcode.
        step(0, 0, 0, 1, 16'h8555, 20, 1);
        step(1, 0, 0, 1, 16'h8666, 21, 1);
        step(0, 0, 0, 1, 16'h0777, 22, 1);
        chk("rst_mid_long.out_inst", 64'(bus.out_inst), 64'h0777);
        chk("rst_mid_long.out_long", 64'(bus.out_long), 64'h0);

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 75, ri, $urandom, 1);
            chk_model("rand");
        end

`ifdef FETCH_BUF_CNT_EN
        // Counter wrap: 65537 short issues leave the count at 1; flush keeps it.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 65537; n++) step(0, 0, 0, 1, 16'h0010, n, 0);
        chk("cnt_wrap", 64'(inst_count), 64'h1);
        step(0, 1, 0, 1, 16'h0011, 0, 0);
        chk("cnt_after_flush", 64'(inst_count), 64'h1);
        chk_model("cnt");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
